// File: rtl/uart_frame_rx.sv
// ----------------------------------------------------------------------------
// uart_frame_rx
//
// Frame decoder sitting behind uart_rx. Hunts for SYNC_BYTE, then takes a
// length byte L (1..MAX_LEN), L payload bytes and a checksum byte C such that
// (L + sum(payload) + C) mod 256 == 0. Clean frames are replayed from an
// internal buffer as a vld/rdy byte stream with a last marker. Bad length,
// bad checksum or an inter-byte gap of TIMEOUT_CYC cycles drops the frame and
// raises a one-cycle error pulse with a cause code.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   uart_rx_data_vld_i/_i/_rdy_o  byte stream in (rdy is registered)
//   frame_data_o/_vld_o/_last_o/_rdy_i  payload stream out
//   frame_err_o                one-cycle error pulse
//   frame_err_code_o           1=LEN, 2=CSUM, 3=TIMEOUT; holds last cause
//
// Optional build macro UART_FRAME_RX_STAT_EN adds saturating counters
//   frame_ok_cnt_o[15:0]  (frames fully delivered)
//   frame_err_cnt_o[15:0] (error pulses)
// ----------------------------------------------------------------------------
module uart_frame_rx #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_data_vld_i,
  input  logic [7:0] uart_rx_data_i,
  output logic       uart_rx_data_rdy_o,
  output logic [7:0] frame_data_o,
  output logic       frame_data_vld_o,
  output logic       frame_data_last_o,
  input  logic       frame_data_rdy_i,
  output logic       frame_err_o,
  output logic [1:0] frame_err_code_o
`ifdef UART_FRAME_RX_STAT_EN
  ,
  output logic [15:0] frame_ok_cnt_o,
  output logic [15:0] frame_err_cnt_o
`endif
);

  localparam int             AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_OUT} state_t;

  state_t        state_reg, state_next;
  logic          rdy_reg, rdy_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    idx_reg, idx_next;
  logic [7:0]    csum_reg, csum_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          vld_reg, vld_next;
  logic          last_reg, last_next;
  logic          err_reg, err_next;
  logic [1:0]    code_reg, code_next;
  logic [7:0]    data_reg;

  logic          mem_we, mem_rd_en;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [7:0]    buf_mem [MAX_LEN];

  logic          accept, xfer, in_frame;
  logic [7:0]    csum_sum;

  assign accept   = uart_rx_data_vld_i & rdy_reg;
  assign xfer     = vld_reg & frame_data_rdy_i;
  assign csum_sum = csum_reg + uart_rx_data_i;
  assign in_frame = (state_reg == S_LEN) || (state_reg == S_PAYLOAD) || (state_reg == S_CSUM);

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    csum_next  = csum_reg;
    tmo_next   = tmo_reg;
    vld_next   = vld_reg;
    last_next  = last_reg;
    err_next   = 1'b0;
    code_next  = code_reg;
    mem_we     = 1'b0;
    mem_rd_en  = 1'b0;
    mem_waddr  = idx_reg[AW-1:0];
    mem_raddr  = idx_reg[AW-1:0];

    case (state_reg)
      S_IDLE: begin
        tmo_next = '0;
        if (accept && uart_rx_data_i == SYNC_BYTE) state_next = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          tmo_next = '0;
          if (uart_rx_data_i == 8'd0 || uart_rx_data_i > MAX_LEN_B) begin
            err_next   = 1'b1;
            code_next  = 2'd1;
            state_next = S_IDLE;
          end else begin
            len_next   = uart_rx_data_i;
            csum_next  = uart_rx_data_i;
            idx_next   = 8'd0;
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          tmo_next  = '0;
          mem_we    = 1'b1;
          csum_next = csum_sum;
          idx_next  = idx_reg + 8'd1;
          if (idx_reg == len_reg - 8'd1) state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          tmo_next = '0;
          if (csum_sum == 8'd0) begin
            // Prefetch buf[0] on this edge so the first byte is valid at once.
            mem_rd_en  = 1'b1;
            mem_raddr  = '0;
            idx_next   = 8'd0;
            vld_next   = 1'b1;
            last_next  = (len_reg == 8'd1);
            state_next = S_OUT;
          end else begin
            err_next   = 1'b1;
            code_next  = 2'd2;
            state_next = S_IDLE;
          end
        end
      end
      S_OUT: begin
        tmo_next = '0;
        if (xfer) begin
          if (last_reg) begin
            vld_next   = 1'b0;
            last_next  = 1'b0;
            state_next = S_IDLE;
          end else begin
            mem_rd_en = 1'b1;
            mem_raddr = AW'(idx_reg + 8'd1);
            idx_next  = idx_reg + 8'd1;
            last_next = ((idx_reg + 8'd1) == (len_reg - 8'd1));
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Inter-byte watchdog: counts idle cycles since the last accepted byte.
    if (in_frame && !accept) begin
      if (tmo_reg == TMO_LAST) begin
        tmo_next   = '0;
        err_next   = 1'b1;
        code_next  = 2'd3;
        state_next = S_IDLE;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end

    // Upstream is held off while the buffer is being replayed.
    rdy_next = (state_next != S_OUT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      rdy_reg   <= 1'b0;
      len_reg   <= 8'd0;
      idx_reg   <= 8'd0;
      csum_reg  <= 8'd0;
      tmo_reg   <= '0;
      vld_reg   <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
      code_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      rdy_reg   <= rdy_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      csum_reg  <= csum_next;
      tmo_reg   <= tmo_next;
      vld_reg   <= vld_next;
      last_reg  <= last_next;
      err_reg   <= err_next;
      code_reg  <= code_next;
    end
  end

  // Payload buffer: write port plus a registered read port whose output
  // register doubles as frame_data_o.
  always_ff @(posedge clk_i) begin
    if (mem_we) buf_mem[mem_waddr] <= uart_rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          data_reg <= 8'd0;
    else if (mem_rd_en) data_reg <= buf_mem[mem_raddr];
  end

  assign uart_rx_data_rdy_o = rdy_reg;
  assign frame_data_o       = data_reg;
  assign frame_data_vld_o   = vld_reg;
  assign frame_data_last_o  = last_reg;
  assign frame_err_o        = err_reg;
  assign frame_err_code_o   = code_reg;

`ifdef UART_FRAME_RX_STAT_EN
  logic [15:0] ok_cnt_reg, err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ok_cnt_reg  <= 16'd0;
      err_cnt_reg <= 16'd0;
    end else begin
      if (xfer && last_reg && ok_cnt_reg != 16'hFFFF) ok_cnt_reg <= ok_cnt_reg + 16'd1;
      if (err_reg && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign frame_ok_cnt_o  = ok_cnt_reg;
  assign frame_err_cnt_o = err_cnt_reg;
`endif

endmodule
